// File: rtl/fdp_reg_bank.sv
// fdp_reg_bank
//   Bank of CHANNELS independent WIDTH-bit registers. It replaces clusters of
//   FDP/FDR preset/clear flops and small counters. Each channel has a
//   synchronous preset (all ones) and a synchronous clear (zero). One selected
//   channel per cycle can also load, shift left or count up/down.
//
//   Priority per channel on each rising CK:
//     RST > SET_CH[c] > CLR_CH[c] > EN operation > hold
//
//   There is no handshake. EN is a plain per-cycle strobe: any input sampled
//   at an edge is reflected on Q/CO right after that edge, and EN may be held
//   high every cycle.
//
// Parameters
//   WIDTH      bits per channel (1..32)
//   CHANNELS   number of channels (1..16)
//   RESET_VAL  value every channel takes on RST, and its power-up value
//
// Ports
//   CK      clock, rising edge
//   RST     synchronous reset, active-high
//   EN      apply MODE to channel CH_SEL this cycle
//   CH_SEL  target channel for EN; out-of-range values select nothing
//   MODE    00 load D, 01 shift left (SI into bit 0), 10 count up, 11 count down
//   D       load data
//   SI      serial input for shift mode
//   SET_CH  per-channel preset to all ones
//   CLR_CH  per-channel clear to zero
//   Q       channel c at Q[c*WIDTH +: WIDTH]
//   nQ      bitwise inverse of Q
//   SO      MSB of channel CH_SEL; 0 when CH_SEL is out of range
//   CO      registered one-cycle wrap pulse per channel
module fdp_reg_bank #(
   parameter int                 WIDTH     = 8,
   parameter int                 CHANNELS  = 4,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0,
   localparam int                SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                        CK,
   input  logic                        RST,
   input  logic                        EN,
   input  logic [SEL_W-1:0]            CH_SEL,
   input  logic [1:0]                  MODE,
   input  logic [WIDTH-1:0]            D,
   input  logic                        SI,
   input  logic [CHANNELS-1:0]         SET_CH,
   input  logic [CHANNELS-1:0]         CLR_CH,
   output logic [CHANNELS*WIDTH-1:0]   Q,
   output logic [CHANNELS*WIDTH-1:0]   nQ,
   output logic                        SO,
   output logic [CHANNELS-1:0]         CO
);

   localparam logic [1:0] MODE_LOAD  = 2'b00;
   localparam logic [1:0] MODE_SHIFT = 2'b01;
   localparam logic [1:0] MODE_UP    = 2'b10;
   localparam logic [1:0] MODE_DOWN  = 2'b11;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      // Declaration initialisers give the power-up state, which matches reset.
      logic [WIDTH-1:0] val_r = RESET_VAL;
      logic             co_r  = 1'b0;
      logic [WIDTH-1:0] shl;
      logic [WIDTH-1:0] nxt;
      logic             wrap;
      logic             hit;

      if (WIDTH == 1) begin : g_sh1
         assign shl = SI;
      end else begin : g_shn
         assign shl = {val_r[WIDTH-2:0], SI};
      end

      // An out-of-range CH_SEL never equals any channel index, so EN is dropped.
      assign hit = EN && (CH_SEL == SEL_W'(c));

      always_comb begin
         nxt  = val_r;
         wrap = 1'b0;
         case (MODE)
            MODE_LOAD:  nxt = D;
            MODE_SHIFT: nxt = shl;
            MODE_UP: begin
               nxt  = val_r + WIDTH'(1);
               wrap = &val_r;
            end
            MODE_DOWN: begin
               nxt  = val_r - WIDTH'(1);
               wrap = ~|val_r;
            end
            default: ;
         endcase
      end

      // CO is cleared on every path except a wrapping EN operation, so it is a
      // single-cycle pulse that repeats only while the wrap condition repeats.
      always_ff @(posedge CK) begin
         if (RST) begin
            val_r <= RESET_VAL;
            co_r  <= 1'b0;
         end else if (SET_CH[c]) begin
            val_r <= '1;
            co_r  <= 1'b0;
         end else if (CLR_CH[c]) begin
            val_r <= '0;
            co_r  <= 1'b0;
         end else if (hit) begin
            val_r <= nxt;
            co_r  <= wrap;
         end else begin
            co_r  <= 1'b0;
         end
      end

      assign Q[c*WIDTH +: WIDTH] = val_r;
      assign CO[c]               = co_r;
   end

   assign nQ = ~Q;

   always_comb begin
      SO = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (CH_SEL == SEL_W'(c)) begin
            SO = Q[c*WIDTH + WIDTH - 1];
         end
      end
   end

endmodule

// File: tb/tb_fdp_reg_bank.sv
// tb_fdp_reg_bank
//   Directed bench for fdp_reg_bank. u_dut4 is the 4-channel 8-bit bank and
//   u_dut3 is a 3-channel bank used for the out-of-range channel select.
//   Both use RESET_VAL 8'h5A. Outputs are sampled 1 ns after the rising edge.
module tb_fdp_reg_bank;

   logic        ck;
   int          errors = 0;
   int          checks = 0;

   // 4-channel instance signals
   logic        rst4, en4, si4;
   logic [1:0]  sel4, mode4;
   logic [7:0]  d4;
   logic [3:0]  set4, clr4;
   logic [31:0] q4, nq4;
   logic        so4;
   logic [3:0]  co4;

   // 3-channel instance signals
   logic        rst3, en3, si3;
   logic [1:0]  sel3, mode3;
   logic [7:0]  d3;
   logic [2:0]  set3, clr3;
   logic [23:0] q3, nq3;
   logic        so3;
   logic [2:0]  co3;

   fdp_reg_bank #(.WIDTH(8), .CHANNELS(4), .RESET_VAL(8'h5A)) u_dut4 (
      .CK(ck), .RST(rst4), .EN(en4), .CH_SEL(sel4), .MODE(mode4), .D(d4),
      .SI(si4), .SET_CH(set4), .CLR_CH(clr4), .Q(q4), .nQ(nq4), .SO(so4),
      .CO(co4)
   );

   fdp_reg_bank #(.WIDTH(8), .CHANNELS(3), .RESET_VAL(8'h5A)) u_dut3 (
      .CK(ck), .RST(rst3), .EN(en3), .CH_SEL(sel3), .MODE(mode3), .D(d3),
      .SI(si3), .SET_CH(set3), .CLR_CH(clr3), .Q(q3), .nQ(nq3), .SO(so3),
      .CO(co3)
   );

   // Clock
   initial ck = 1'b0;
   always #5 ck = ~ck;

   // Time limit so the run always ends
   initial begin
      #20000;
      $display("FAIL watchdog: time limit reached, got running, need finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, need %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   initial begin
      rst4 = 1'b1; en4 = 1'b0; si4 = 1'b0; sel4 = 2'd0; mode4 = 2'd0;
      d4 = 8'h00; set4 = 4'h0; clr4 = 4'h0;
      rst3 = 1'b1; en3 = 1'b0; si3 = 1'b0; sel3 = 2'd0; mode3 = 2'd0;
      d3 = 8'h00; set3 = 3'h0; clr3 = 3'h0;
      #1;
      check("powerup_q", q4, 32'h5A5A_5A5A);

      // Reset
      step();
      check("rst_q", q4, 32'h5A5A_5A5A);
      check("rst_nq", nq4, 32'hA5A5_A5A5);
      check("rst_co", co4, 4'h0);
      check("rst_so", so4, 1'b0);
      check("rst_q3", q3, 24'h5A_5A5A);
      rst4 = 1'b0;
      rst3 = 1'b0;

      // Load channel 2 and hold
      en4 = 1'b1; mode4 = 2'b00; sel4 = 2'd2; d4 = 8'h3C;
      step();
      check("load_q", q4, 32'h5A3C_5A5A);
      en4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_q", q4, 32'h5A3C_5A5A);
      end
      check("hold_nq", nq4, 32'hA5C3_A5A5);

      // Count wrap on channel 1
      en4 = 1'b1; mode4 = 2'b00; sel4 = 2'd1; d4 = 8'hFE;
      step();
      check("cnt_load", q4, 32'h5A3C_FE5A);
      mode4 = 2'b10;
      step();
      check("up_ff", q4, 32'h5A3C_FF5A);
      check("up_ff_co", co4, 4'b0000);
      step();
      check("up_00", q4, 32'h5A3C_005A);
      check("up_00_co", co4, 4'b0010);
      step();
      check("up_01", q4, 32'h5A3C_015A);
      check("up_01_co", co4, 4'b0000);
      mode4 = 2'b11;
      step();
      check("dn_00", q4, 32'h5A3C_005A);
      check("dn_00_co", co4, 4'b0000);
      step();
      check("dn_ff", q4, 32'h5A3C_FF5A);
      check("dn_ff_co", co4, 4'b0010);
      en4 = 1'b0;
      step();
      check("idle_co", co4, 4'b0000);

      // Shift on channel 0
      en4 = 1'b1; mode4 = 2'b00; sel4 = 2'd0; d4 = 8'h81;
      step();
      check("sh_load", q4, 32'h5A3C_FF81);
      mode4 = 2'b01; si4 = 1'b0;
      #1;
      check("sh_so_pre", so4, 1'b1);
      step();
      check("sh_02", q4, 32'h5A3C_FF02);
      si4 = 1'b1;
      step();
      check("sh_05", q4, 32'h5A3C_FF05);
      check("sh_so_post", so4, 1'b0);

      // Priority on channel 3
      mode4 = 2'b10; sel4 = 2'd3;
      step();
      check("pri_cnt", q4, 32'h5B3C_FF05);
      set4 = 4'b1000; clr4 = 4'b1000;
      step();
      check("pri_set", q4, 32'hFF3C_FF05);
      check("pri_set_co", co4, 4'b0000);
      // Channel 3 is all ones, so an EN count would wrap here; set must win.
      step();
      check("pri_set2", q4, 32'hFF3C_FF05);
      check("pri_set2_co", co4, 4'b0000);
      set4 = 4'b0000;
      step();
      check("pri_clr", q4, 32'h003C_FF05);
      check("pri_clr_co", co4, 4'b0000);
      clr4 = 4'b0000;
      step();
      check("pri_resume", q4, 32'h013C_FF05);
      en4 = 1'b0; sel4 = 2'd1;
      #1;
      check("so_sel1", so4, 1'b1);
      sel4 = 2'd2;
      #1;
      check("so_sel2", so4, 1'b0);

      // Reset in the middle of counting
      en4 = 1'b1; mode4 = 2'b10; sel4 = 2'd1;
      step();
      check("mid_wrap", q4, 32'h013C_0005);
      check("mid_wrap_co", co4, 4'b0010);
      rst4 = 1'b1;
      step();
      check("mid_rst", q4, 32'h5A5A_5A5A);
      check("mid_rst_co", co4, 4'b0000);
      rst4 = 1'b0;
      step();
      check("mid_res1", q4, 32'h5A5A_5B5A);
      step();
      check("mid_res2", q4, 32'h5A5A_5C5A);
      en4 = 1'b0;

      // Out-of-range channel select on the 3-channel bank
      en3 = 1'b1; sel3 = 2'd3; mode3 = 2'b00; d3 = 8'hAA;
      step();
      check("oor_load", q3, 24'h5A_5A5A);
      check("oor_load_co", co3, 3'b000);
      mode3 = 2'b11;
      step();
      check("oor_down", q3, 24'h5A_5A5A);
      check("oor_down_co", co3, 3'b000);
      mode3 = 2'b00; sel3 = 2'd2;
      step();
      check("inr_load", q3, 24'hAA_5A5A);
      check("inr_nq", nq3, 24'h55_A5A5);
      en3 = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fdp_reg_bank.md
# fdp_reg_bank

Parametrised multi-channel register bank: the next generation of the single-bit preset/clear flip-flop cell. It holds CHANNELS independent WIDTH-bit registers, each with a synchronous preset and clear and a selectable load, shift or up/down count operation. It sits among the core's cell library as a drop-in for clusters of FDP/FDR-style flops and small counters in the video and timing logic. All state changes are synchronous to CK; the polarity of preset/clear is active-high.

## Interface
- WIDTH, 8: bits per channel register (1..32).
- CHANNELS, 4: number of independent registers (1..16).
- RESET_VAL, 0: WIDTH-bit value every channel takes on RST.
- CK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous reset, active-high.
- EN  input  1  perform MODE operation on channel CH_SEL this cycle.
- CH_SEL  input  $clog2(CHANNELS) (min 1)  channel targeted by EN.
- MODE  input  2  00 load D, 01 shift left, 10 count up, 11 count down.
- D  input  WIDTH  load data.
- SI  input  1  serial input shifted into bit 0 in shift mode.
- SET_CH  input  CHANNELS  per-channel preset, active-high: channel becomes all ones.
- CLR_CH  input  CHANNELS  per-channel clear, active-high: channel becomes zero.
- Q  output  CHANNELS*WIDTH  registers, channel c at Q[c*WIDTH +: WIDTH].
- nQ  output  CHANNELS*WIDTH  bitwise inverse of Q (combinational).
- SO  output  1  MSB of channel CH_SEL (combinational).
- CO  output  CHANNELS  registered wrap flag, one pulse per wrap.

## Operation
- Per channel c, per rising CK, priority: RST > SET_CH[c] > CLR_CH[c] > EN operation > hold.
- RST: every channel <= RESET_VAL; CO <= 0.
- SET_CH[c]: channel c <= all ones; CO[c] <= 0. Set beats clear when both asserted (same priority as the legacy cell).
- CLR_CH[c]: channel c <= 0; CO[c] <= 0.
- EN operation only on channel CH_SEL, only if that channel has no SET/CLR this cycle; otherwise discarded, no partial effect.
- MODE 00: channel <= D.
- MODE 01: channel <= {channel[WIDTH-2:0], SI}; WIDTH=1 gives channel <= SI.
- MODE 10: channel <= channel + 1 mod 2^WIDTH; if old value all ones, CO[c] <= 1.
- MODE 11: channel <= channel - 1 mod 2^WIDTH; if old value zero, CO[c] <= 1.
- CO[c] is 0 on every cycle where the condition above does not apply (one-cycle pulse); channels not selected keep CO at 0.
- CH_SEL >= CHANNELS with EN: no channel changes, CO all 0.
- SO and nQ follow Q combinationally; SO uses the current CH_SEL.

## Timing
- Reset values: Q = RESET_VAL replicated, nQ = ~Q, CO = 0, SO = MSB of RESET_VAL.
- Latency: any control/data input sampled at edge N is visible on Q and CO after edge N; one cycle, no pipeline.
- No handshake; EN may be held every cycle (count or shift at full clock rate, consecutive wraps give consecutive CO pulses only when the wrap condition repeats).
- RST mid-count or mid-shift aborts immediately; the next cycle resumes from RESET_VAL.
- Power-up before first RST: Q = RESET_VAL (initial value), matching the reset state.

## Test plan
- Reset: WIDTH=8, CHANNELS=4, RESET_VAL=8'h5A, assert RST one cycle -> all four channels 8'h5A, nQ 8'hA5 each, CO=0.
- Load and hold: EN=1, MODE=00, CH_SEL=2, D=8'h3C, then EN=0 for 3 cycles -> channel 2 = 8'h3C throughout, channels 0,1,3 unchanged.
- Count wrap: channel 1 loaded 8'hFE, MODE=10 EN=1 for 3 cycles -> 8'hFF, 8'h00 with CO[1]=1 that cycle only, 8'h01 with CO[1]=0; down-count from 8'h01 -> 8'h00, 8'hFF with CO[1]=1.
- Shift: channel 0 = 8'h81, MODE=01, SI=0,1 -> 8'h02 (SO=1 before first edge), then 8'h05.
- Priority: channel 3 counting, assert SET_CH[3] and CLR_CH[3] with EN=1 CH_SEL=3 -> channel 3 = 8'hFF, CO[3]=0; CLR_CH[3] alone next cycle -> 8'h00.
- Out of range and reset mid-op: CHANNELS=3, CH_SEL=3 EN=1 MODE=00 D=8'hAA -> no change; RST during count -> RESET_VAL next cycle, count resumes from it.
